lsu_dmem_ctrl: RTL and testbench

//  Load/store unit between the execute stage and the 64x32 data memory. Accepts one request per valid/ready handshake.

---
 rtl/lsu_dmem_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store unit between execute and the 64x32 dmem (byte enables, lane steering, load extension).
// Latency: accept edge N -> resp_valid in cycle N+2 (faults skip the memory cycle, N+1); one access in flight.
// Backpressure: req_ready only in IDLE; the response holds while resp_ready is low. Optional MISALIGN_TRAP_EN.
module lsu_dmem_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [3:0]  mem_byteEnable,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_fault;

  logic        w_accept;
  logic        w_bad_f3;
  logic        w_oor;
  logic        w_misalign;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept = req_valid && req_ready;

  // Classify the incoming request: anything faulting never reaches the memory
  always_comb begin
    w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
               (req_we && req_funct3[2]);
    w_oor    = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`ifdef MISALIGN_TRAP_EN
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Offending low bits are simply ignored by the lane logic below
    w_misalign = 1'b0;
`endif
    w_fault = w_bad_f3 || w_oor || w_misalign;
  end

  // State register; reset drops any pending write because mem_we decodes from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Capture the request on the accept edge; held for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_funct3 <= 3'd0;
      r_we     <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
      r_we     <= req_we;
      r_fault  <= w_fault;
    end
  end

  // Next-state: IDLE -> ISSUE -> RESP -> IDLE, faults go straight to RESP
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_fault ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane select and extension of the registered memory word. mem_rd only moves on
  // edges with mem_we=1, so it is stable for the whole RESP phase.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rd[7:0];
      2'd1:    w_byte = mem_rd[15:8];
      2'd2:    w_byte = mem_rd[23:16];
      default: w_byte = mem_rd[31:24];
    endcase
    w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rd;
    endcase
  end

  // Outputs decoded from state; memory port is idle (all zero) outside ISSUE
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'd0;
    resp_fault     = 1'b0;
    mem_we         = 1'b0;
    mem_byteEnable = 4'b0000;
    mem_a          = 32'd0;
    mem_wd         = 32'd0;
    case (r_state)
      S_IDLE: req_ready = rst_n;
      S_ISSUE: begin
        // Loads also pulse we with no byte enables so dmem latches rd
        mem_we = 1'b1;
        mem_a  = {r_addr[31:2], 2'b00};
        if (r_we) begin
          case (r_funct3[1:0])
            2'b00: begin
              mem_byteEnable = 4'b0001 << r_addr[1:0];
              mem_wd         = {4{r_wdata[7:0]}};
            end
            2'b01: begin
              mem_byteEnable = 4'b0011 << {r_addr[1], 1'b0};
              mem_wd         = {2{r_wdata[15:0]}};
            end
            default: begin
              mem_byteEnable = 4'b1111;
              mem_wd         = r_wdata;
            end
          endcase
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_rdata = (r_we || r_fault) ? 32'd0 : w_load;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: behavioural 64x32 dmem, scoreboard queue of expected responses.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [3:0]  mem_byteEnable;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] dmem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_dat;

  lsu_dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_byteEnable(mem_byteEnable), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] n;
    n = old;
    for (int b = 0; b < 4; b++) if (be[b]) n[8*b +: 8] = wd[8*b +: 8];
    return n;
  endfunction

  // Data memory: registered read, rd updates only on write-enabled edges
  always @(posedge clk) begin
    if (bd_we) dmem[bd_idx] <= bd_dat;
    else if (mem_we) begin
      dmem[mem_a[7:2]] <= merge(dmem[mem_a[7:2]], mem_wd, mem_byteEnable);
      mem_rd           <= merge(dmem[mem_a[7:2]], mem_wd, mem_byteEnable);
    end
  end

  function automatic logic [31:0] init_val(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] ld_model(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_model(logic [31:0] old, logic [2:0] f3, logic [1:0] off, logic [31:0] wd);
    logic [31:0] n;
    n = old;
    case (f3[1:0])
      2'b00:   n[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   if (off[1]) n[31:16] = wd[15:0]; else n[15:0] = wd[15:0];
      default: n = wd;
    endcase
    return n;
  endfunction

  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_dat = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Drive one request and return what the DUT showed up to the first response cycle
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdata, output logic fault, output logic saw_we,
                      output logic [3:0] be, output logic [31:0] a, output logic [31:0] wdo, output logic to);
    int cyc;
    to = 1'b0; saw_we = 1'b0; be = 4'h0; a = 32'h0; wdo = 32'h0; lat = 0; rdata = 32'h0; fault = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (mem_we && !saw_we) begin saw_we = 1'b1; be = mem_byteEnable; a = mem_a; wdo = mem_wd; end
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) to = 1'b1;
    rdata = resp_rdata; fault = resp_fault;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp got v=%b d=%h f=%b want 0/0/0", resp_valid, resp_rdata, resp_fault); end
    n_checks++; if ({mem_we, mem_byteEnable, mem_a, mem_wd} !== 69'h0) begin
      n_fail++; $display("FAIL rst_mem got we=%b be=%b a=%h wd=%h want 0", mem_we, mem_byteEnable, mem_a, mem_wd); end
    for (int i = 0; i < 64; i++) poke(6'(i), init_val(i));
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_idle_ready got %b want 1", req_ready); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [0:6];
    logic [31:0] ads [0:6];
    logic [31:0] exs [0:6];
    int lat; logic [31:0] rd, a, wdo; logic ft, sw, to; logic [3:0] be; exp_t e;
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    ads = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h10, 32'h13, 32'h10};
    exs = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_1234, 32'h0000_80F0, 32'h1234_80F0, 32'h0000_0012, 32'hFFFF_80F0};
    poke(6'd4, 32'h1234_80F0);
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{rdata: exs[i], fault: 1'b0});
      send(1'b0, f3s[i], ads[i], 32'h0, lat, rd, ft, sw, be, a, wdo, to);
      e = sb_q.pop_front();
      n_checks++; if (to || lat != 2) begin n_fail++; $display("FAIL load%0d_latency got %0d (to=%b) want 2", i, lat, to); end
      n_checks++; if (!sw || be !== 4'b0000 || a !== 32'h10) begin
        n_fail++; $display("FAIL load%0d_issue got we=%b be=%b a=%h want 1/0000/10", i, sw, be, a); end
      n_checks++; if (rd !== e.rdata || ft !== e.fault) begin
        n_fail++; $display("FAIL load%0d_data got %h f=%b want %h f=%b", i, rd, ft, e.rdata, e.fault); end
      ack();
    end
  endtask

  task automatic test_sb();
    int lat; logic [31:0] rd, a, wdo; logic ft, sw, to; logic [3:0] be; exp_t e;
    sb_q.push_back('{rdata: 32'h0, fault: 1'b0});
    send(1'b1, 3'b000, 32'h13, 32'hAABB_CCDD, lat, rd, ft, sw, be, a, wdo, to);
    e = sb_q.pop_front();
    n_checks++; if (to || lat != 2) begin n_fail++; $display("FAIL sb_latency got %0d (to=%b) want 2", lat, to); end
    n_checks++; if (a !== 32'h10 || be !== 4'b1000 || wdo !== 32'hDDDD_DDDD) begin
      n_fail++; $display("FAIL sb_issue got a=%h be=%b wd=%h want 10/1000/DDDDDDDD", a, be, wdo); end
    n_checks++; if (rd !== e.rdata || ft !== e.fault) begin
      n_fail++; $display("FAIL sb_resp got %h f=%b want %h f=%b", rd, ft, e.rdata, e.fault); end
    ack();
    n_checks++; if (dmem[4] !== 32'hDD34_80F0) begin n_fail++; $display("FAIL sb_word got %h want DD3480F0", dmem[4]); end
  endtask

  task automatic test_sh_lw_backpressure();
    int lat; logic [31:0] rd, a, wdo; logic ft, sw, to; logic [3:0] be; exp_t e;
    poke(6'd8, 32'h1111_2222);
    sb_q.push_back('{rdata: 32'h0, fault: 1'b0});
    send(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, lat, rd, ft, sw, be, a, wdo, to);
    e = sb_q.pop_front();
    n_checks++; if (to || a !== 32'h20 || be !== 4'b1100 || wdo !== 32'hBEEF_BEEF) begin
      n_fail++; $display("FAIL sh_issue got a=%h be=%b wd=%h to=%b want 20/1100/BEEFBEEF", a, be, wdo, to); end
    n_checks++; if (rd !== e.rdata || ft !== e.fault) begin n_fail++; $display("FAIL sh_resp got %h f=%b want 0", rd, ft); end
    ack();
    sb_q.push_back('{rdata: 32'hBEEF_2222, fault: 1'b0});
    send(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, ft, sw, be, a, wdo, to);
    e = sb_q.pop_front();
    n_checks++; if (to || rd !== e.rdata || ft !== e.fault) begin
      n_fail++; $display("FAIL lw_after_sh got %h f=%b want %h", rd, ft, e.rdata); end
    // Offer a competing store while the response is stalled; it must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_fault !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d_resp got v=%b d=%h f=%b want 1/%h/0", c, resp_valid, resp_rdata, resp_fault, e.rdata); end
      n_checks++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d_idle got rdy=%b we=%b want 0/0", c, req_ready, mem_we); end
    end
    req_valid = 1'b0;
    ack();
    n_checks++; if (dmem[0] !== init_val(0)) begin n_fail++; $display("FAIL hold_ignored got %h want %h", dmem[0], init_val(0)); end
  endtask

  task automatic test_faults();
    logic        wes [0:4];
    logic [2:0]  f3s [0:4];
    logic [31:0] ads [0:4];
    int lat; logic [31:0] rd, a, wdo; logic ft, sw, to; logic [3:0] be; exp_t e;
    wes = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    f3s = '{3'b010, 3'b011, 3'b100, 3'b111, 3'b000};
    ads = '{32'h100, 32'h10, 32'h10, 32'h10, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{rdata: 32'h0, fault: 1'b1});
      send(wes[i], f3s[i], ads[i], 32'h1234_5678, lat, rd, ft, sw, be, a, wdo, to);
      e = sb_q.pop_front();
      n_checks++; if (to || lat != 1 || sw) begin
        n_fail++; $display("FAIL fault%0d_path got lat=%0d we=%b to=%b want 1/0/0", i, lat, sw, to); end
      n_checks++; if (rd !== e.rdata || ft !== e.fault) begin
        n_fail++; $display("FAIL fault%0d_resp got %h f=%b want %h f=%b", i, rd, ft, e.rdata, e.fault); end
      ack();
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd, a, wdo; logic ft, sw, to; logic [3:0] be; exp_t e;
    logic [31:0] ads [0:1];
    logic [2:0]  f3s [0:1];
    logic [31:0] vals [0:1];
    ads = '{32'h05, 32'h11}; f3s = '{3'b010, 3'b001}; vals = '{init_val(1), 32'hFFFF_80F0};
    for (int i = 0; i < 2; i++) begin
`ifdef MISALIGN_TRAP_EN
      sb_q.push_back('{rdata: 32'h0, fault: 1'b1});
`else
      sb_q.push_back('{rdata: vals[i], fault: 1'b0});
`endif
      send(1'b0, f3s[i], ads[i], 32'h0, lat, rd, ft, sw, be, a, wdo, to);
      e = sb_q.pop_front();
      n_checks++; if (to || sw !== !e.fault) begin
        n_fail++; $display("FAIL misalign%0d_memcycle got we=%b to=%b want %b", i, sw, to, !e.fault); end
      n_checks++; if (rd !== e.rdata || ft !== e.fault) begin
        n_fail++; $display("FAIL misalign%0d_resp got %h f=%b want %h f=%b", i, rd, ft, e.rdata, e.fault); end
      ack();
    end
  endtask

  task automatic test_reset_mid_issue();
    int cyc;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_a !== 32'h30) begin
      n_fail++; $display("FAIL rstmid_issue got we=%b a=%h want 1/30", mem_we, mem_a); end
    #2; rst_n = 1'b0; #1;
    n_checks++; if (mem_we !== 1'b0 || mem_byteEnable !== 4'h0 || mem_a !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_drop got we=%b be=%b a=%h want 0", mem_we, mem_byteEnable, mem_a); end
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hs got v=%b rdy=%b want 0/0", resp_valid, req_ready); end
    @(posedge clk); #1;
    n_checks++; if (dmem[12] !== init_val(12)) begin
      n_fail++; $display("FAIL rstmid_word got %h want %h", dmem[12], init_val(12)); end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle got rdy=%b v=%b we=%b want 1/0/0", req_ready, resp_valid, mem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sh [0:15];
    int lat; logic [31:0] rd, a, wdo, wd, ad; logic ft, sw, to, we; logic [3:0] be; exp_t e;
    logic [2:0] f3; logic [1:0] off; int w;
    for (int i = 0; i < 16; i++) sh[i] = dmem[i];
    for (int t = 0; t < 30; t++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 2));
      if (!we && $urandom_range(0, 2) == 0) f3[2] = 1'b1;
      if (f3[1:0] == 2'b10) f3[2] = 1'b0;
      w   = $urandom_range(0, 15);
      off = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) : (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      ad  = {24'd0, 6'(w), off};
      wd  = $urandom;
      if (we) begin
        sb_q.push_back('{rdata: 32'h0, fault: 1'b0});
        sh[w] = st_model(sh[w], f3, off, wd);
      end else sb_q.push_back('{rdata: ld_model(sh[w], f3, off), fault: 1'b0});
      send(we, f3, ad, wd, lat, rd, ft, sw, be, a, wdo, to);
      e = sb_q.pop_front();
      n_checks++; if (to || lat != 2 || rd !== e.rdata || ft !== e.fault) begin
        n_fail++; $display("FAIL rand%0d we=%b f3=%b a=%h got %h f=%b lat=%0d want %h f=%b", t, we, f3, ad, rd, ft, lat, e.rdata, e.fault); end
      ack();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_ready got %b want 1", t, req_ready); end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (dmem[i] !== sh[i]) begin n_fail++; $display("FAIL rand_word%0d got %h want %h", i, dmem[i], sh[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; bd_we = 1'b0; bd_idx = 6'd0; bd_dat = 32'h0;
    test_reset();
    test_load_ext();
    test_sb();
    test_sh_lw_backpressure();
    test_faults();
    test_misalign();
    test_reset_mid_issue();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
